siso_frame_tx: RTL and testbench

Parallel-to-serial frame transmitter that drives the `si` input of the serial-in/serial-out shift register stage directly. It accepts a WIDTH-bit word over a valid/ready handshake and emits a start-bit-framed bitstream on one serial line, MSB first. An even parity bit is optional. It lets upstream parallel logic feed the SISO delay chain without hand-sequencing bits.

---
 rtl/siso_frame_tx.sv | 135 +++++++++++++
 tb/tb_siso_frame_tx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/siso_frame_tx.sv
// siso_frame_tx: parallel-to-serial frame transmitter feeding a SISO chain.
// Frame on so: start bit (1), WIDTH data bits MSB first, optional even
// parity bit, stop bit (0). The line idles at 0.
// Optional feature macro: SISO_FRAME_TX_PARITY_EN (adds the parity bit).
module siso_frame_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SISO_FRAME_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_shift, w_shift_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic             r_so, w_so_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             w_accept;
`ifdef SISO_FRAME_TX_PARITY_EN
  logic             r_par, w_par_next;
`endif

  // A new word is only taken while idle or in the stop-bit cycle.
  assign din_ready  = (r_state == S_IDLE) || (r_state == S_STOP);
  assign w_accept   = din_valid && din_ready;
  assign so         = r_so;
  assign busy       = r_busy;
  assign frame_done = r_done;

  // State and registered outputs; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_so    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SISO_FRAME_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
      r_so    <= w_so_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
`ifdef SISO_FRAME_TX_PARITY_EN
      r_par   <= w_par_next;
`endif
    end
  end

  // Next-state logic; so/frame_done are computed one cycle ahead so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    w_so_next    = r_so;
    w_done_next  = 1'b0;
`ifdef SISO_FRAME_TX_PARITY_EN
    w_par_next   = r_par;
`endif
    case (r_state)
      S_IDLE, S_STOP: begin
        if (w_accept) begin
          w_shift_next = din;
          w_cnt_next   = '0;
          w_so_next    = 1'b1;
          w_state_next = S_START;
`ifdef SISO_FRAME_TX_PARITY_EN
          w_par_next   = ^din;
`endif
        end else begin
          w_so_next    = 1'b0;
          w_state_next = S_IDLE;
        end
      end
      S_START: begin
        w_so_next    = r_shift[WIDTH-1];
        w_state_next = S_DATA;
      end
      S_DATA: begin
        w_shift_next = r_shift << 1;
        w_cnt_next   = r_cnt + 1'b1;
        w_so_next    = r_shift[WIDTH-2];
        if (r_cnt == LAST_BIT) begin
          w_cnt_next   = '0;
`ifdef SISO_FRAME_TX_PARITY_EN
          w_so_next    = r_par;
          w_state_next = S_PARITY;
`else
          w_so_next    = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef SISO_FRAME_TX_PARITY_EN
      S_PARITY: begin
        w_so_next    = 1'b0;
        w_done_next  = 1'b1;
        w_state_next = S_STOP;
      end
`endif
      default: begin
        w_so_next    = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

endmodule

// File: tb/tb_siso_frame_tx.sv
// Testbench for siso_frame_tx (WIDTH=8). Expected frames are built from the
// framing rules: start 1, data MSB first, optional even parity, stop 0.
module tb_siso_frame_tx;

  localparam int W = 8;
`ifdef SISO_FRAME_TX_PARITY_EN
  localparam int L = W + 3;
`else
  localparam int L = W + 2;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, so, busy, frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  siso_frame_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .so         (so),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial image of one frame, in transmit order.
  task automatic build_frame(input logic [W-1:0] w, output logic exp[L]);
    int k;
    k = 0;
    exp[k] = 1'b1; k++;
    for (int b = W - 1; b >= 0; b--) begin
      exp[k] = w[b]; k++;
    end
`ifdef SISO_FRAME_TX_PARITY_EN
    exp[k] = ($countones(w) % 2) == 1; k++;
`endif
    exp[k] = 1'b0;
  endtask

  // Caller is at a negedge with din=w, din_valid=1 and the DUT ready.
  // Checks all L frame cycles; at the stop cycle presents the next word.
  task automatic send(input logic [W-1:0] w, input bit b2b, input logic [W-1:0] nxt,
                      input bit garble);
    logic exp[L];
    build_frame(w, exp);
    @(posedge clk);
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      check($sformatf("so[%0d] w=%02h", i, w), so, exp[i]);
      check($sformatf("busy[%0d]", i), busy, 1'b1);
      check($sformatf("done[%0d]", i), frame_done, (i == L - 1));
      check($sformatf("ready[%0d]", i), din_ready, (i == L - 1));
      if (i < L - 1) begin
        if (garble) begin
          din       = W'($urandom);
          din_valid = 1'($urandom);
        end else begin
          din_valid = 1'b0;
        end
      end else begin
        din       = nxt;
        din_valid = b2b;
      end
    end
    $display("frame w=%02h b2b=%0d garble=%0d", w, b2b, garble);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " so"}, so, 1'b0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " done"}, frame_done, 1'b0);
    check({tag, " ready"}, din_ready, 1'b1);
  endtask

  initial begin
    logic [W-1:0] w, nxt;
    logic exp[L];
    bit b;

    // Reset state
    #1;
    check_idle("reset");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle so[%0d]", i), so, 1'b0);
    end
    $display("reset and idle checked");

    // Single frames
    din = 8'hA5; din_valid = 1'b1;
    send(8'hA5, 1'b0, 8'h00, 1'b0);
    @(negedge clk); check_idle("after A5");
    din = 8'h07; din_valid = 1'b1;
    send(8'h07, 1'b0, 8'h00, 1'b0);
    @(negedge clk); check_idle("after 07");

    // Back-to-back 81 then 3C
    din = 8'h81; din_valid = 1'b1;
    send(8'h81, 1'b1, 8'h3C, 1'b0);
    send(8'h3C, 1'b0, 8'h00, 1'b0);
    @(negedge clk); check_idle("after 3C");

    // Backpressure: din/din_valid wiggle mid-frame
    din = 8'h5A; din_valid = 1'b1;
    send(8'h5A, 1'b0, 8'h00, 1'b1);
    @(negedge clk); check_idle("after 5A");

    // Reset during the frame, then a clean FF frame
    din = 8'hC3; din_valid = 1'b1;
    build_frame(8'hC3, exp);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      check($sformatf("pre-reset so[%0d]", i), so, exp[i]);
    end
    #2 reset = 1'b0;
    #1 check_idle("async reset");
    @(negedge clk); check_idle("held reset");
    reset = 1'b1;
    @(negedge clk); check_idle("post reset");
    $display("mid-frame reset checked");
    din = 8'hFF; din_valid = 1'b1;
    send(8'hFF, 1'b0, 8'h00, 1'b0);
    @(negedge clk); check_idle("after FF");

    // Random words, random back-to-back chaining and input noise
    w = W'($urandom);
    din = w; din_valid = 1'b1;
    for (int k = 0; k < 24; k++) begin
      nxt = W'($urandom);
      b   = 1'($urandom);
      send(w, b, nxt, 1'($urandom));
      if (!b) begin
        @(negedge clk);
        check_idle("rand gap");
        din = nxt; din_valid = 1'b1;
      end
      w = nxt;
    end
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
